bus_arbiter_n: RTL and testbench



---
 rtl/bus_arbiter_n_if.sv | 33 +++
 rtl/bus_arbiter_n.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter_n.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_n_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_n_if
// Purpose  : CPU-side request and per-target return signals for bus_arbiter_n.
// Revision : 1.0
// ============================================================================
interface bus_arbiter_n_if #(
    parameter int SOURCES    = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int IW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

    logic                          cpu_valid;
    logic [3:0]                    cpu_wstrb;
    logic [SOURCES-1:0]            source_en;
    logic [SOURCES-1:0]            source_ready;
    logic [SOURCES*DATA_WIDTH-1:0] source_read_data;
    logic                          cpu_mem_ready;
    logic [DATA_WIDTH-1:0]         cpu_read_data;
    logic                          bus_error;
    logic [IW-1:0]                 error_source;

    modport master (
        output cpu_valid, cpu_wstrb, source_en, source_ready, source_read_data,
        input  cpu_mem_ready, cpu_read_data, bus_error, error_source
    );

    modport slave (
        input  cpu_valid, cpu_wstrb, source_en, source_ready, source_read_data,
        output cpu_mem_ready, cpu_read_data, bus_error, error_source
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter_n
// Purpose  : Return arbiter for N targets; completes one outstanding access
//            from target ready or a fixed wait-state count. Watchdog enabled
//            by defining BUS_ARBITER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module bus_arbiter_n #(
    parameter int                               SOURCES            = 8,
    parameter int                               DATA_WIDTH         = 32,
    parameter int                               LATENCY_WIDTH      = 3,
    parameter logic [SOURCES*LATENCY_WIDTH-1:0] SOURCE_LATENCY     = '0,
    parameter int                               DEFAULT_SOURCE     = 0,
    parameter bit                               REGISTER_READ_DATA = 1'b0,
    parameter int                               TIMEOUT_CYCLES     = 255,
    localparam int                              IW = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    bus_arbiter_n_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [IW-1:0]            r_idx;
    logic [IW-1:0]            w_first_idx;
    logic                     w_any_sel;
    logic [LATENCY_WIDTH-1:0] r_wait_cnt;
    logic [LATENCY_WIDTH-1:0] w_first_lat;
    logic [LATENCY_WIDTH-1:0] w_cur_lat;
    logic                     w_load;
    logic                     w_wdog_run;
    logic                     w_wdog_expire;
    logic                     w_to_err;
    logic                     w_bus_error;
    logic                     w_unused;

    logic [DATA_WIDTH-1:0]    w_data_tbl [SOURCES];
    logic [LATENCY_WIDTH-1:0] w_lat_tbl  [SOURCES];

    for (genvar gi = 0; gi < SOURCES; gi++) begin : g_tbl
        assign w_data_tbl[gi] = bus.source_read_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_lat_tbl[gi]  = SOURCE_LATENCY[gi*LATENCY_WIDTH +: LATENCY_WIDTH];
    end

    // Lowest set select bit wins when the decoder asserts more than one.
    always_comb begin
        w_first_idx = '0;
        w_any_sel   = 1'b0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (bus.source_en[i]) begin
                w_first_idx = IW'(i);
                w_any_sel   = 1'b1;
            end
        end
    end

    assign w_first_lat = w_lat_tbl[w_first_idx];
    assign w_cur_lat   = w_lat_tbl[r_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_wdog_run  = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_valid) begin
                    if (w_any_sel) begin
                        w_load      = 1'b1;
                        w_state_nxt = (w_first_lat == '0 && bus.source_ready[w_first_idx])
                                      ? S_ACK : S_WAIT;
                    end else begin
                        w_wdog_run = 1'b1;
                        if (w_wdog_expire) begin
                            w_state_nxt = S_ACK;
                            w_to_err    = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!bus.cpu_valid) begin
                    w_state_nxt = S_IDLE;
                end else if ((w_cur_lat == '0) ? bus.source_ready[r_idx]
                                                : (r_wait_cnt == LATENCY_WIDTH'(1))) begin
                    w_state_nxt = S_ACK;
                end else begin
                    // A normal completion above takes priority over the watchdog.
                    w_wdog_run = 1'b1;
                    if (w_wdog_expire) begin
                        w_state_nxt = S_ACK;
                        w_to_err    = 1'b1;
                    end
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_idx      <= w_first_idx;
                r_wait_cnt <= w_first_lat;
            end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - LATENCY_WIDTH'(1);
            end
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int             WDW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] c_wdog_last = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] r_wdog;
    logic           r_bus_error;
    logic [IW-1:0]  r_err_src;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wdog      <= '0;
            r_bus_error <= 1'b0;
            r_err_src   <= '0;
        end else begin
            r_wdog      <= w_wdog_run ? (r_wdog + WDW'(1)) : '0;
            r_bus_error <= w_to_err;
            if (w_to_err) begin
                r_err_src <= (r_state == S_IDLE) ? '1 : r_idx;
            end
        end
    end

    assign w_wdog_expire    = (r_wdog == c_wdog_last);
    assign w_bus_error      = r_bus_error;
    assign bus.bus_error    = r_bus_error;
    assign bus.error_source = r_err_src;
`else
    assign w_wdog_expire    = 1'b0;
    assign w_bus_error      = 1'b0;
    assign bus.bus_error    = 1'b0;
    assign bus.error_source = '0;
`endif

    assign bus.cpu_mem_ready = (r_state == S_ACK);

    if (REGISTER_READ_DATA) begin : g_reg_rdata
        logic [IW-1:0]         w_next_idx;
        logic [DATA_WIDTH-1:0] r_rdata;

        assign w_next_idx = (r_state == S_IDLE) ? w_first_idx : r_idx;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_rdata <= '0;
            end else if (w_state_nxt == S_ACK) begin
                r_rdata <= w_to_err ? '1 : w_data_tbl[w_next_idx];
            end
        end
        assign bus.cpu_read_data = r_rdata;
    end else begin : g_comb_rdata
        assign bus.cpu_read_data = (r_state == S_ACK)
                                   ? (w_bus_error ? '1 : w_data_tbl[r_idx])
                                   : w_data_tbl[DEFAULT_SOURCE];
    end

    // Write strobes do not alter the handshake.
    assign w_unused = ^{bus.cpu_wstrb, w_wdog_run, w_to_err, (TIMEOUT_CYCLES != 0)};
endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_n.sv
`default_nettype none
// Bench for bus_arbiter_n: two DUTs (combinational / registered return data)
// share stimulus and are compared every cycle against a transaction model.
module tb_bus_arbiter_n;
    localparam int          NS   = 8;
    localparam int          DW   = 32;
    localparam int          TMO  = 10;
    localparam logic [23:0] LATV = {3'd7, 3'd2, 3'd0, 3'd1, 3'd4, 3'd0, 3'd0, 3'd0};
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    int lat_of [NS] = '{0, 0, 0, 4, 1, 0, 2, 7};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_n_if #(.SOURCES(NS), .DATA_WIDTH(DW)) bus0 ();
    bus_arbiter_n_if #(.SOURCES(NS), .DATA_WIDTH(DW)) bus1 ();

    assign bus1.cpu_valid        = bus0.cpu_valid;
    assign bus1.cpu_wstrb        = bus0.cpu_wstrb;
    assign bus1.source_en        = bus0.source_en;
    assign bus1.source_ready     = bus0.source_ready;
    assign bus1.source_read_data = bus0.source_read_data;

    bus_arbiter_n #(.SOURCES(NS), .DATA_WIDTH(DW), .LATENCY_WIDTH(3), .SOURCE_LATENCY(LATV),
                    .DEFAULT_SOURCE(0), .REGISTER_READ_DATA(1'b0), .TIMEOUT_CYCLES(TMO))
        u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

    bus_arbiter_n #(.SOURCES(NS), .DATA_WIDTH(DW), .LATENCY_WIDTH(3), .SOURCE_LATENCY(LATV),
                    .DEFAULT_SOURCE(0), .REGISTER_READ_DATA(1'b1), .TIMEOUT_CYCLES(TMO))
        u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] src_data(input int i);
        return bus0.source_read_data[i*DW +: DW];
    endfunction

    // ---------------- transaction-level reference model ----------------
    int          e = 0;
    int          m_k = 0, m_acc = 0, m_ucnt = 0;
    bit          m_pend = 0, m_ack = 0, m_err = 0, m_wr = 0, m_cap_ok = 1;
    logic [31:0] m_cap = '0;
    logic [2:0]  m_esrc = '0;

    task automatic m_complete(input bit err, input logic [2:0] esrc);
        m_ack    = 1'b1;
        m_pend   = 1'b0;
        m_err    = err;
        m_ucnt   = 0;
        if (err) m_esrc = esrc;
        m_cap    = err ? 32'hFFFF_FFFF : src_data(m_k);
        m_cap_ok = err || !m_wr;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 0; m_ack = 0; m_err = 0; m_ucnt = 0;
            m_cap = '0; m_esrc = '0; m_cap_ok = 1;
        end else begin
            e++;
            if (m_ack) begin
                m_ack = 0; m_err = 0; m_ucnt = 0;
            end else if (!m_pend) begin
                if (bus0.cpu_valid && bus0.source_en != '0) begin
                    for (int i = NS - 1; i >= 0; i--) if (bus0.source_en[i]) m_k = i;
                    m_acc  = e;
                    m_wr   = (bus0.cpu_wstrb != 4'd0);
                    m_ucnt = 0;
                    if (lat_of[m_k] == 0 && bus0.source_ready[m_k]) m_complete(1'b0, 3'd0);
                    else m_pend = 1'b1;
                end else if (bus0.cpu_valid && TO_EN) begin
                    m_ucnt++;
                    if (m_ucnt == TMO) begin
                        m_wr = (bus0.cpu_wstrb != 4'd0);
                        m_complete(1'b1, 3'd7);
                    end
                end else begin
                    m_ucnt = 0;
                end
            end else begin
                if (!bus0.cpu_valid) m_pend = 1'b0;
                else if (lat_of[m_k] == 0 ? bus0.source_ready[m_k] : (e - m_acc == lat_of[m_k]))
                    m_complete(1'b0, 3'd0);
                else if (TO_EN && (e - m_acc == TMO))
                    m_complete(1'b1, 3'(m_k));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready0", {31'd0, bus0.cpu_mem_ready}, {31'd0, m_ack});
            check("ready1", {31'd0, bus1.cpu_mem_ready}, {31'd0, m_ack});
            check("berr0", {31'd0, bus0.bus_error}, {31'd0, m_ack && m_err});
            check("berr1", {31'd0, bus1.bus_error}, {31'd0, m_ack && m_err});
            check("esrc0", {29'd0, bus0.error_source}, {29'd0, m_esrc});
            check("esrc1", {29'd0, bus1.error_source}, {29'd0, m_esrc});
            if (m_ack) begin
                if (m_err || !m_wr)
                    check("rdata0_ack", bus0.cpu_read_data, m_err ? 32'hFFFF_FFFF : src_data(m_k));
            end else begin
                check("rdata0_idle", bus0.cpu_read_data, src_data(0));
            end
            if (m_cap_ok) check("rdata1", bus1.cpu_read_data, m_cap);
        end
    end

    // Called just after a rising edge; ready of rdy_tgt first sampled high rdy_at edges after accept.
    task automatic access(input logic [7:0] en, input int rdy_tgt, input int rdy_at, input int budget,
                          output int lat, output logic [31:0] d0, output logic berr, output logic [2:0] esrc);
        bus0.cpu_valid = 1'b1;
        bus0.cpu_wstrb = 4'd0;
        bus0.source_en = en;
        if (rdy_tgt >= 0 && rdy_at == 0) bus0.source_ready[rdy_tgt] = 1'b1;
        lat = -1; d0 = '0; berr = 1'b0; esrc = '0;
        @(posedge clk);
        for (int n = 1; n <= budget; n++) begin
            #2;
            if (rdy_tgt >= 0 && n == rdy_at) bus0.source_ready[rdy_tgt] = 1'b1;
            @(negedge clk);
            if (bus0.cpu_mem_ready) begin
                lat = n; d0 = bus0.cpu_read_data; berr = bus0.bus_error; esrc = bus0.error_source;
                break;
            end
            @(posedge clk);
        end
        @(posedge clk); #2;
        bus0.cpu_valid    = 1'b0;
        bus0.source_en    = '0;
        bus0.source_ready = '0;
        @(negedge clk);
        check("no_second_pulse", {31'd0, bus0.cpu_mem_ready}, 32'd0);
        @(posedge clk); #2;
    endtask

    function automatic logic [7:0] rand_en();
        logic [7:0] r;
        if ($urandom_range(0, 1) == 0) r = 8'd1 << $urandom_range(0, 7);
        else r = 8'($urandom_range(0, 255));
        if (!TO_EN && r == 8'd0) r = 8'd1;
        return r;
    endfunction

    initial begin
        int          lat;
        logic [31:0] d0;
        logic        berr;
        logic [2:0]  esrc;

        bus0.cpu_valid = 1'b0; bus0.cpu_wstrb = 4'd0; bus0.source_en = '0;
        bus0.source_ready = '0; bus0.source_read_data = '0;
        for (int i = 0; i < NS; i++) bus0.source_read_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);

        @(posedge clk); #2;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, bus0.cpu_mem_ready}, 32'd0);
        check("rst_berr", {31'd0, bus0.bus_error}, 32'd0);
        check("rst_esrc", {29'd0, bus0.error_source}, 32'd0);
        check("rst_rdata_reg", bus1.cpu_read_data, 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #2;

        bus0.source_read_data[2*DW +: DW] = 32'h1234_5678;
        access(8'b0000_0100, 2, 0, 20, lat, d0, berr, esrc);
        check("ready_at_accept_lat", 32'(lat), 32'd1);
        check("ready_at_accept_data", d0, 32'h1234_5678);
        bus0.source_read_data[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clk);
        check("reg_data_hold", bus1.cpu_read_data, 32'h1234_5678);
        @(posedge clk); #2;

        access(8'b0000_1000, -1, 0, 20, lat, d0, berr, esrc);
        check("fixed_lat4", 32'(lat), 32'd5);

        access(8'b0000_0110, 1, 6, 20, lat, d0, berr, esrc);
        check("late_ready_lat", 32'(lat), 32'd7);
        check("late_ready_data", d0, 32'hA000_0001);

`ifdef BUS_ARBITER_TIMEOUT_EN
        access(8'b0000_0000, -1, 0, 30, lat, d0, berr, esrc);
        check("unmapped_lat", 32'(lat), 32'd10);
        check("unmapped_berr", {31'd0, berr}, 32'd1);
        check("unmapped_data", d0, 32'hFFFF_FFFF);
        check("unmapped_esrc", {29'd0, esrc}, 32'd7);
        access(8'b0010_0000, -1, 0, 30, lat, d0, berr, esrc);
        check("hung_lat", 32'(lat), 32'd11);
        check("hung_berr", {31'd0, berr}, 32'd1);
        check("hung_esrc", {29'd0, esrc}, 32'd5);
`endif

        bus0.cpu_valid = 1'b1; bus0.source_en = 8'b0000_1000;
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b0; bus0.cpu_valid = 1'b0; bus0.source_en = '0;
        #1;
        check("midrst_ready", {31'd0, bus0.cpu_mem_ready}, 32'd0);
        check("midrst_berr", {31'd0, bus0.bus_error}, 32'd0);
        check("midrst_esrc", {29'd0, bus0.error_source}, 32'd0);
        check("midrst_rdata_reg", bus1.cpu_read_data, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        access(8'b0000_1000, -1, 0, 20, lat, d0, berr, esrc);
        check("after_rst_lat", 32'(lat), 32'd5);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NS; i++) bus0.source_read_data[i*DW +: DW] = $urandom;
            bus0.source_ready = 8'($urandom) & 8'($urandom);
            if (!bus0.cpu_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus0.cpu_valid = 1'b1;
                    bus0.source_en = rand_en();
                    bus0.cpu_wstrb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                end
            end else if ($urandom_range(0, 30) == 0) begin
                bus0.cpu_valid = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                bus0.source_en = rand_en();
            end
            if (bus0.cpu_valid && bus0.cpu_mem_ready && $urandom_range(0, 1) == 0) bus0.cpu_valid = 1'b0;
            @(posedge clk); #2;
        end
        bus0.cpu_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "bench time limit exceeded");
    end
endmodule
`default_nettype wire
